// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The master side is the producer/consumer and the slave side is the FIFO.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
);
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rinc;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output winc, wdata, rinc, clr_err,
        input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, clr_err,
        output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_flags_if.slave fif
);
    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  full_w;
    logic                  empty_w;
    logic                  wr_ok;
    logic                  rd_ok;

    function automatic logic [ADDR_WIDTH:0] next_count(
        input logic [ADDR_WIDTH:0] cnt,
        input logic                wr,
        input logic                rd
    );
        case ({wr, rd})
            2'b10:   next_count = cnt + 1'b1;
            2'b01:   next_count = cnt - 1'b1;
            default: next_count = cnt;
        endcase
    endfunction

    // A set event on the same edge as a clear keeps the flag set.
    function automatic logic next_sticky(
        input logic cur,
        input logic set,
        input logic clr
    );
        next_sticky = set | (cur & ~clr);
    endfunction

    // Accept decisions look only at the registered (pre-edge) occupancy.
    assign full_w  = (count_r == DEPTH_CNT);
    assign empty_w = (count_r == '0);
    assign wr_ok   = fif.winc & ~full_w;
    assign rd_ok   = fif.rinc & ~empty_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            count_r     <= next_count(count_r, wr_ok, rd_ok);
            overflow_r  <= next_sticky(overflow_r, fif.winc & full_w, fif.clr_err);
            underflow_r <= next_sticky(underflow_r, fif.rinc & empty_w, fif.clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wptr] <= fif.wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign fif.rdata = empty_w ? '0 : mem[rptr];
`else
    logic [DATA_WIDTH-1:0] rdata_p1;

    // Read stage: head word is registered on the accepting edge and held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= '0;
        end else if (rd_ok) begin
            rdata_p1 <= mem[rptr];
        end
    end

    assign fif.rdata = rdata_p1;
`endif

    assign fif.full         = full_w;
    assign fif.empty        = empty_w;
    assign fif.almost_full  = (count_r >= AF_CNT);
    assign fif.almost_empty = (count_r <= AE_CNT);
    assign fif.count        = count_r;
    assign fif.overflow     = overflow_r;
    assign fif.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: stimulus queues expected read words, a monitor checks them.
module tb_sync_fifo_flags;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sync_fifo_flags_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) fif ();

    sync_fifo_flags #(
        .DATA_WIDTH(4),
        .ADDR_WIDTH(4),
        .AF_LEVEL  (12),
        .AE_LEVEL  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fif(fif)
    );

    always #5 clk = ~clk;

    logic [3:0] exp_q[$];   // expected read stream, in order
    logic [3:0] m_q[$];     // model FIFO contents
    int         m_cnt = 0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances from pre-edge state, then flags are compared.
    task automatic cycle(input logic w, input logic [3:0] d, input logic r,
                         input logic clr, input logic rs);
        logic m_full;
        logic m_empty;
        fif.winc    = w;
        fif.wdata   = d;
        fif.rinc    = r;
        fif.clr_err = clr;
        rst         = rs;
        if (rs) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_full  = (m_q.size() == 16);
            m_empty = (m_q.size() == 0);
            if (r && !m_empty) exp_q.push_back(m_q.pop_front());
            if (w && !m_full) m_q.push_back(d);
            m_ovf = (w && m_full) || (m_ovf && !clr);
            m_unf = (r && m_empty) || (m_unf && !clr);
        end
        m_cnt = m_q.size();
        @(posedge clk);
        #1;
        chk("count", 32'(fif.count), 32'(m_cnt));
        chk("full", 32'(fif.full), 32'(m_cnt == 16));
        chk("empty", 32'(fif.empty), 32'(m_cnt == 0));
        chk("almost_full", 32'(fif.almost_full), 32'(m_cnt >= 12));
        chk("almost_empty", 32'(fif.almost_empty), 32'(m_cnt <= 2));
        chk("overflow", 32'(fif.overflow), 32'(m_ovf));
        chk("underflow", 32'(fif.underflow), 32'(m_unf));
    endtask

    // Read-stream monitor, sampled on the falling edge while inputs are stable.
    logic pend = 1'b0;
    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_stream: got %0h expected no word", fif.rdata);
            end else begin
                chk("rdata", 32'(fif.rdata), 32'(exp_q.pop_front()));
            end
        end
        pend = 1'b0;
        if (!rst && fif.rinc && !fif.empty) begin
`ifdef SYNC_FIFO_FWFT_EN
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_stream: got %0h expected no word", fif.rdata);
            end else begin
                chk("rdata_fwft", 32'(fif.rdata), 32'(exp_q.pop_front()));
            end
`else
            pend = 1'b1;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fif.winc = 1'b0; fif.wdata = '0; fif.rinc = 1'b0; fif.clr_err = 1'b0;

        // Reset, then idle.
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        chk("rst_rdata", 32'(fif.rdata), 32'h0);
        chk("rst_count", 32'(fif.count), 32'd0);
        chk("rst_empty", 32'(fif.empty), 32'd1);

        // Fill with 1..F, 0 then overflow with A.
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 4'(i), 0, 0, 0);
            if (i == 11) chk("af_at_11", 32'(fif.almost_full), 32'd0);
            if (i == 12) chk("af_at_12", 32'(fif.almost_full), 32'd1);
        end
        chk("fill_count", 32'(fif.count), 32'd16);
        chk("fill_full", 32'(fif.full), 32'd1);
        cycle(1, 4'hA, 0, 0, 0);
        chk("ovf_set", 32'(fif.overflow), 32'd1);
        chk("ovf_count", 32'(fif.count), 32'd16);

        // Drain 16 words, then read once more while empty.
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 0);
        chk("drain_empty", 32'(fif.empty), 32'd1);
        cycle(0, 0, 1, 0, 0);
        chk("unf_set", 32'(fif.underflow), 32'd1);
        cycle(0, 0, 0, 1, 0);
        chk("clr_both", 32'({fif.overflow, fif.underflow}), 32'd0);

        // Hold count at 5 with simultaneous read/write across two wraps.
        for (int i = 0; i < 5; i++) cycle(1, 4'(i), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cycle(1, 4'(i + 5), 1, 0, 0);
            if (i == 39) chk("steady_count", 32'(fif.count), 32'd5);
        end

        // Full with both requests: read taken, write dropped.
        for (int i = 0; i < 11; i++) cycle(1, 4'(i + 3), 0, 0, 0);
        cycle(1, 4'h7, 1, 0, 0);
        chk("full_rw_count", 32'(fif.count), 32'd15);
        chk("full_rw_ovf", 32'(fif.overflow), 32'd1);
        cycle(0, 0, 0, 1, 0);
        chk("ovf_cleared", 32'(fif.overflow), 32'd0);

        // Empty with both requests: write taken, read ignored.
        for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0, 0);
        cycle(1, 4'h9, 1, 0, 0);
        chk("empty_rw_count", 32'(fif.count), 32'd1);
        chk("empty_rw_unf", 32'(fif.underflow), 32'd1);
        cycle(0, 0, 1, 0, 0);
        // Set and clear on the same edge: set wins.
        cycle(0, 0, 1, 1, 0);
        chk("set_beats_clr", 32'(fif.underflow), 32'd1);
        cycle(0, 0, 0, 1, 0);

        // Reset mid-operation discards in-flight data.
        for (int i = 0; i < 8; i++) cycle(1, 4'(i + 8), 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("midrst_count", 32'(fif.count), 32'd0);
        chk("midrst_empty", 32'(fif.empty), 32'd1);
        chk("midrst_rdata", 32'(fif.rdata), 32'h0);
        cycle(1, 4'hC, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
